spm_boot_loader: RTL and testbench
==================================

# spm_boot_loader

Initiator-side program loader for the SPM memory port. It accepts a byte stream over a valid/ready handshake and writes it into the memory unit through its address / data_in / write port while holding the processor in reset. It then reads the image back to verify its checksum and releases the processor only on a match. It sits between an external byte source and the memory unit, muxed ahead of the processor's memory connection.

## Interface
- word_size, 8, data byte width
- addr_size, 8, memory address width; image length 1..2^addr_size

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored while busy
- byte_valid  in  1  byte_data is valid
- byte_data  in  word_size  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- mem_addr  out  addr_size  memory address
- mem_data  out  word_size  write data to memory data_in
- mem_write  out  1  memory write strobe, one cycle per byte
- mem_rdata  in  word_size  memory data_out, combinational read of mem_addr
- cpu_rst  out  1  active-low processor reset; low = processor held
- busy  out  1  load or verify in progress
- done  out  1  image verified, processor released; sticky until next start
- error  out  1  checksum mismatch; sticky until next start

## Operation
- Stream format: LEN byte, then N data bytes, then CSUM byte.
  - LEN = 0 means N = 2^addr_size.
  - CSUM = 8-bit sum of data bytes, mod 256.
- States and transitions:
  - IDLE -> LEN on start.
  - LEN -> DATA on LEN accept.
  - DATA -> CSUM after the Nth data accept.
  - CSUM -> VERIFY on CSUM accept.
  - VERIFY -> DONE or ERROR after N reads plus a compare cycle.
  - DONE / ERROR -> LEN on start.
- Byte accept: byte_valid && byte_ready at a rising edge.
- byte_ready = 1 only in LEN, DATA and CSUM; byte_valid is ignored elsewhere.
- DATA: accepted byte k is written to address k (k = 0..N-1), in order.
- Data-byte sum accumulates at each DATA accept; it is not used for the decision.
- VERIFY:
  - mem_addr steps 0..N-1, one address per cycle.
  - mem_rdata is summed mod 256.
  - The readback sum is compared with the received CSUM.
  - Equal -> DONE; unequal -> ERROR.
- cpu_rst = 0 in every state except DONE.
- start from DONE drops cpu_rst to 0 in the cycle after the start edge.
- busy = 1 in LEN, DATA, CSUM and VERIFY.
- Address and count counters are addr_size+1 bits, so N = 2^addr_size terminates without wrap ambiguity.
- mem_addr wraps naturally only after the final address.

## Timing
- Reset values: byte_ready 0, mem_addr 0, mem_data 0, mem_write 0, cpu_rst 0, busy 0, done 0, error 0; state IDLE.
- Write pipeline: accept at edge t registers mem_addr/mem_data and sets mem_write = 1 for the cycle t..t+1. The memory writes at edge t+1.
- Back-to-back accepts are supported: mem_write stays high, with a new address and data every cycle.
- The CSUM accept is at least one edge after the last data accept. The last write is therefore complete before VERIFY reads it.
- VERIFY latency: N cycles of reads, then 1 compare cycle. done or error asserts on the edge that ends the compare cycle.
- Minimum total time from start edge to done: 1 + 1 + N + 1 + N + 1 cycles, with byte_valid held high.
- Reset mid-load: all outputs return to reset values immediately (asynchronous). The partially written memory content is don't-care.
- start coincident with byte_valid in IDLE: the byte is not accepted; byte_ready rises the cycle after start.

## Structure
- Shared package spm_pkg:
  - loader state enum (IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERROR)
  - word_size / addr_size constants shared with the processor and memory unit
- Sub-module spm_sum8:
  - 8-bit mod-256 accumulator with synchronous clear and add-enable
  - one instance for the data-byte sum, one for the readback sum
- FSM, counters and the write register stay in spm_boot_loader.

## Test plan
- LEN=4, data 0x11 0x22 0x33 0x44, CSUM=0xAA, continuous valid -> addresses 0..3 hold the data; four consecutive mem_write cycles; done=1, cpu_rst=1, error=0.
- Same image with CSUM=0xAB -> error=1, done=0, cpu_rst stays 0, busy drops.
- LEN=0 with 256 bytes of value i, CSUM=0x80 -> writes to addresses 0..255 with no wrap; done=1 after 2*256+4 cycles minimum.
- Random byte_valid gaps and a byte_valid pulse while in VERIFY -> no extra writes; memory image identical to the gap-free case.
- Assert rst low in the middle of DATA -> outputs immediately reach reset values. A new start and image after release loads correctly.
- start while busy is ignored. start in DONE drops cpu_rst to 0 the cycle after the start edge, and a second load completes.

Source files
------------

// File: rtl/spm_pkg.sv
// spm_pkg
// Shared definitions for the SPM memory port: data/address widths used by
// the processor, the memory unit and the boot loader, plus the loader's
// state encoding.
// Ports: none (package).
package spm_pkg;

  localparam int WORD_SIZE = 8;
  localparam int ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  // States in which the byte stream handshake is open.
  function automatic logic is_stream_state(input loader_state_e st);
    return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
  endfunction

  // States in which a new load may be started.
  function automatic logic is_rest_state(input loader_state_e st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/spm_sum8.sv
// spm_sum8
// 8-bit modulo-256 accumulator with synchronous clear and add-enable.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           clear the sum to zero at the next edge (wins over add_en)
//   add_en        add add_val into the sum at the next edge
//   add_val       value to accumulate
//   sum           current registered sum
module spm_sum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_val,
  output logic [7:0] sum
);

  logic [7:0] sum_d;
  logic [7:0] sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/spm_boot_loader.sv
// spm_boot_loader
// Loads a LEN / data / CSUM byte stream into the SPM memory unit while the
// processor is held in reset, reads the image back, and releases the
// processor only if the readback sum matches the received checksum.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start                  begin a load (from IDLE, DONE or ERROR)
//   byte_valid/byte_data   incoming stream byte
//   byte_ready             loader accepts a byte this cycle
//   mem_addr/mem_data      memory address and write data
//   mem_write              one-cycle write strobe per data byte
//   mem_rdata              combinational read data for mem_addr
//   cpu_rst                active-low processor reset (high only in DONE)
//   busy, done, error      load status
module spm_boot_loader
  import spm_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [word_size-1:0] byte_data,
  output logic                 byte_ready,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_rdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // One extra bit so that an image of 2^addr_size bytes has a representable
  // length and the counters never alias back to zero before the end.
  localparam int cnt_w = addr_size + 1;
  localparam logic [cnt_w-1:0]     cnt_one  = 1;
  localparam logic [addr_size-1:0] addr_one = 1;

  loader_state_e        state_q, state_d;
  logic [cnt_w-1:0]     len_q, len_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [word_size-1:0] csum_q, csum_d;
  logic [addr_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_data_q, mem_data_d;
  logic                 mem_write_q, mem_write_d;
  logic                 byte_ready_q, byte_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 cpu_rst_q, cpu_rst_d;

  logic                 accept;
  logic                 sum_clr;
  logic                 reading;
  logic [7:0]           data_sum_unused;
  logic [7:0]           rb_sum;

  assign accept  = byte_valid && byte_ready_q;
  assign sum_clr = start && is_rest_state(state_q);
  // VERIFY spends len cycles reading, then one cycle with cnt == len comparing.
  assign reading = (state_q == ST_VERIFY) && (cnt_q != len_q);

  // Sum of the streamed data bytes; kept for observation only, the pass/fail
  // decision is made on what actually landed in memory.
  spm_sum8 u_data_sum (
    .clk     (clk),
    .rst     (rst),
    .clr     (sum_clr),
    .add_en  (accept && (state_q == ST_DATA)),
    .add_val (byte_data),
    .sum     (data_sum_unused)
  );

  spm_sum8 u_rb_sum (
    .clk     (clk),
    .rst     (rst),
    .clr     (sum_clr),
    .add_en  (reading),
    .add_val (mem_rdata),
    .sum     (rb_sum)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          // A zero length byte stands for the full address space.
          if (byte_data == '0) begin
            len_d = {1'b1, {addr_size{1'b0}}};
          end else begin
            len_d = {1'b0, byte_data[addr_size-1:0]};
          end
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          mem_addr_d  = cnt_q[addr_size-1:0];
          mem_data_d  = byte_data;
          mem_write_d = 1'b1;
          cnt_d       = cnt_q + cnt_one;
          if ((cnt_q + cnt_one) == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          csum_d     = byte_data;
          cnt_d      = '0;
          mem_addr_d = '0;
          state_d    = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (reading) begin
          cnt_d      = cnt_q + cnt_one;
          mem_addr_d = mem_addr_q + addr_one;
        end else begin
          state_d = (rb_sum == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered along
    // with it and change on the same edge as the state.
    byte_ready_d = is_stream_state(state_d);
    busy_d       = is_stream_state(state_d) || (state_d == ST_VERIFY);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    cpu_rst_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_write_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_write_q  <= mem_write_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_write  = mem_write_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_rst    = cpu_rst_q;

endmodule

// File: tb/tb_spm_boot_loader.sv
// tb_spm_boot_loader
// Self-checking bench for spm_boot_loader. Holds an ideal memory model,
// logs every write the loader issues, and checks each load against a
// reference built from the stream rules: byte k lands at address k, the
// load passes iff the data bytes sum to CSUM mod 256, and a gap-free load
// takes 2N+3 edges after the start edge to reach DONE/ERROR.
module tb_spm_boot_loader;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_write;
  logic [7:0] mem_rdata;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       error;

  logic [7:0] mem [DEPTH];
  int         cyc = 0;
  int         wr_addr_q[$];
  int         wr_data_q[$];
  int         wr_cyc_q[$];

  logic [7:0] img [DEPTH];
  int         img_n;
  logic [7:0] img_csum;

  int n_checks = 0;
  int n_miscompares = 0;

  spm_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Ideal memory: combinational read, write on the edge ending the strobe.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_addr] <= mem_data;
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_data));
      wr_cyc_q.push_back(cyc);
    end
  end

  // Full load: start pulse (with a junk byte offered in the same cycle),
  // stream LEN/data/CSUM, wait for the verdict, then check everything.
  task automatic run_load(input string name, input bit gaps, input bit noise,
                          input int busy_start_idx, input bit check_time);
    logic [7:0] stream[$];
    logic [7:0] sum;
    bit         exp_ok;
    bit         v;
    bit         rdy;
    bit         extra_start_done;
    int         i;
    int         base;
    int         t_start;
    int         budget;
    int         n;
    int         bad_k;
    int         latency;

    n = img_n;
    sum = 8'h00;
    stream.push_back((n == DEPTH) ? 8'h00 : 8'(n));
    for (int j = 0; j < n; j++) begin
      stream.push_back(img[j]);
      sum = sum + img[j];
    end
    stream.push_back(img_csum);
    exp_ok = (sum == img_csum);
    base = wr_addr_q.size();

    @(negedge clk);
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b0;
    t_start = cyc;

    n_checks++;
    if ({byte_ready, busy, cpu_rst, done, error} !== 5'b11000) begin
      n_miscompares++;
      $display("[TB] FAIL %s after-start {ready,busy,cpu_rst,done,error}: got %b expected 11000",
               name, {byte_ready, busy, cpu_rst, done, error});
    end

    i = 0;
    budget = 0;
    extra_start_done = 1'b0;
    while (i < stream.size() && budget < 4000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = byte_ready;
      byte_valid = v;
      byte_data = stream[i];
      start = 1'b0;
      if (i == busy_start_idx && !extra_start_done) begin
        start = 1'b1;
        extra_start_done = 1'b1;
      end
      if (v && rdy) i++;
      @(negedge clk);
      budget++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    n_checks++;
    if (i != stream.size()) begin
      n_miscompares++;
      $display("[TB] FAIL %s stream-accept: got %0d bytes accepted expected %0d", name, i, stream.size());
    end

    budget = 0;
    while (!(done || error) && budget < 2000) begin
      if (noise) begin
        byte_valid = ($urandom_range(0, 1) != 0);
        byte_data = 8'($urandom);
      end
      @(negedge clk);
      budget++;
    end
    latency = cyc - t_start;
    byte_valid = 1'b0;
    if (noise) begin
      repeat (3) begin
        byte_valid = 1'b1;
        @(negedge clk);
      end
      byte_valid = 1'b0;
    end

    n_checks++;
    if ({done, error, cpu_rst, busy, byte_ready} !== {exp_ok, !exp_ok, exp_ok, 1'b0, 1'b0}) begin
      n_miscompares++;
      $display("[TB] FAIL %s verdict {done,error,cpu_rst,busy,ready}: got %b expected %b", name,
               {done, error, cpu_rst, busy, byte_ready}, {exp_ok, !exp_ok, exp_ok, 1'b0, 1'b0});
    end

    n_checks++;
    if (wr_addr_q.size() - base != n) begin
      n_miscompares++;
      $display("[TB] FAIL %s write-count: got %0d expected %0d", name, wr_addr_q.size() - base, n);
    end else begin
      bad_k = -1;
      for (int k = 0; k < n; k++) begin
        if (bad_k < 0 && (wr_addr_q[base+k] != k || wr_data_q[base+k] != int'(img[k]))) bad_k = k;
      end
      n_checks++;
      if (bad_k >= 0) begin
        n_miscompares++;
        $display("[TB] FAIL %s write-order at #%0d: got addr %0d data %02h expected addr %0d data %02h",
                 name, bad_k, wr_addr_q[base+bad_k], wr_data_q[base+bad_k], bad_k, img[bad_k]);
      end
      if (!gaps) begin
        bad_k = -1;
        for (int k = 1; k < n; k++) begin
          if (bad_k < 0 && wr_cyc_q[base+k] != wr_cyc_q[base] + k) bad_k = k;
        end
        n_checks++;
        if (bad_k >= 0) begin
          n_miscompares++;
          $display("[TB] FAIL %s back-to-back at #%0d: got cycle %0d expected %0d", name, bad_k,
                   wr_cyc_q[base+bad_k], wr_cyc_q[base] + bad_k);
        end
      end
    end

    bad_k = -1;
    for (int k = 0; k < n; k++) begin
      if (bad_k < 0 && mem[k] !== img[k]) bad_k = k;
    end
    n_checks++;
    if (bad_k >= 0) begin
      n_miscompares++;
      $display("[TB] FAIL %s mem-image at %0d: got %02h expected %02h", name, bad_k, mem[bad_k], img[bad_k]);
    end

    // Start edge, LEN, N data, CSUM, N reads, compare: 2N+3 edges after start.
    if (check_time && !gaps) begin
      n_checks++;
      if (latency != 2 * n + 3) begin
        n_miscompares++;
        $display("[TB] FAIL %s latency: got %0d edges expected %0d", name, latency, 2 * n + 3);
      end
    end
  endtask

  task automatic make_random_image(input int n, input bit good);
    logic [7:0] s;
    s = 8'h00;
    img_n = n;
    for (int k = 0; k < n; k++) begin
      img[k] = 8'($urandom);
      s = s + img[k];
    end
    img_csum = good ? s : s + 8'($urandom_range(1, 255));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #3;
    n_checks++;
    if ({byte_ready, mem_addr, mem_data, mem_write, cpu_rst, busy, done, error} !== 22'h0) begin
      n_miscompares++;
      $display("[TB] FAIL reset-values: got %h expected 0",
               {byte_ready, mem_addr, mem_data, mem_write, cpu_rst, busy, done, error});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // IDLE must ignore byte_valid entirely.
    byte_valid = 1'b1;
    byte_data = 8'h5A;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    n_checks++;
    if ({byte_ready, mem_write, cpu_rst, busy, done, error} !== 6'b0 || wr_addr_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL idle-ignore: got flags %b writes %0d expected 000000 and 0",
               {byte_ready, mem_write, cpu_rst, busy, done, error}, wr_addr_q.size());
    end
  endtask

  task automatic test_basic_pass();
    img_n = 4;
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    img_csum = 8'hAA;
    run_load("basic_pass", 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_bad_csum();
    img_n = 4;
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    img_csum = 8'hAB;
    run_load("bad_csum", 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_full_256();
    img_n = DEPTH;
    for (int k = 0; k < DEPTH; k++) img[k] = 8'(k);
    img_csum = 8'h80;
    run_load("full_256", 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 6; r++) begin
      make_random_image($urandom_range(1, 40), (r % 3) != 2);
      run_load("random_gaps", 1'b1, 1'b1, -1, 1'b0);
    end
    make_random_image(1, 1'b1);
    run_load("single_byte", 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_reset_mid_data();
    int base;
    make_random_image(10, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'd10;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      byte_data = img[k];
      @(negedge clk);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({byte_ready, mem_addr, mem_data, mem_write, cpu_rst, busy, done, error} !== 22'h0) begin
      n_miscompares++;
      $display("[TB] FAIL mid-data-reset: got %h expected 0",
               {byte_ready, mem_addr, mem_data, mem_write, cpu_rst, busy, done, error});
    end
    byte_valid = 1'b0;
    base = wr_addr_q.size();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != base || busy !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL post-reset-idle: got writes %0d busy %b expected 0 and 0",
               wr_addr_q.size() - base, busy);
    end
    make_random_image(12, 1'b1);
    run_load("after_reset", 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_start_busy_and_restart();
    make_random_image(8, 1'b1);
    run_load("start_while_busy", 1'b0, 1'b0, 4, 1'b1);
    make_random_image(5, 1'b1);
    run_load("restart_from_done", 1'b0, 1'b0, -1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_pass();
    test_bad_csum();
    test_full_256();
    test_random_gaps();
    test_reset_mid_data();
    test_start_busy_and_restart();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
